button_press_classifier: RTL and testbench
==========================================

Name: button_press_classifier

Overview:
- Sits directly downstream of the button debouncer.
- Consumes the clean, clock-synchronous button level and classifies user gestures into single-cycle event pulses: short press, double press, long press, and auto-repeat while held.
- Feeds the control/UI logic, which then never deals with raw press timing.

Parameters:
- LONG_CYCLES, 50_000_000, press duration in cycles that qualifies as a long press (1 s at 50 MHz); must be ≥ 2.
- GAP_CYCLES, 12_500_000, maximum release-to-second-press gap in cycles for a double press (250 ms); must be ≥ 2.
- REPEAT_CYCLES, 10_000_000, auto-repeat period in cycles after a long press (200 ms); 0 disables repeat.
- CNT_W, 26, counter width; must hold max(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES) − 1.

Ports:
- i_clk  in  1  system clock, 50 MHz
- i_rst  in  1  reset, asynchronous, active-high
- i_button  in  1  debounced button level, already synchronous to i_clk; 1 = pressed
- o_short_press  out  1  one-cycle pulse: single short press confirmed
- o_double_press  out  1  one-cycle pulse: second press of a double press released
- o_long_press  out  1  one-cycle pulse: hold reached LONG_CYCLES
- o_repeat  out  1  one-cycle pulse every REPEAT_CYCLES while held after a long press
- o_busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Clocking and reset
  - Reset: i_rst asserts asynchronously on i_clk; state = IDLE, counter = 0, all outputs 0.
  - All outputs are registered.
  - Each event pulse is high for exactly the one cycle following the clock edge that decides the event.
  - At most one event pulse is high in any cycle.
- Counter
  - Single shared counter, width CNT_W.
  - Cleared to 0 on every state change.
  - Increments once per cycle while in a counting state.
  - Never wraps: every terminal value causes a state change or clear first.
- FSM states and transitions (all decisions use i_button sampled at the clock edge):
  - IDLE: i_button = 1 → PRESS1.
  - PRESS1:
    - i_button = 0 → WAIT_GAP.
    - Else, counter == LONG_CYCLES−1 → pulse o_long_press, go to LONG_HELD.
    - Else, increment.
    - Long pulse therefore follows the edge LONG_CYCLES edges after the press edge.
  - WAIT_GAP:
    - i_button = 1 → PRESS2.
    - Else, counter == GAP_CYCLES−1 → pulse o_short_press, go to IDLE.
    - Else, increment.
    - Short-press latency is GAP_CYCLES edges after the release edge.
  - PRESS2:
    - i_button = 0 → pulse o_double_press, go to IDLE.
    - Hold duration is ignored and the counter is idle.
  - LONG_HELD:
    - i_button = 0 → IDLE, with no further pulse.
    - Else, if REPEAT_CYCLES ≠ 0 and counter == REPEAT_CYCLES−1 → pulse o_repeat, clear counter.
    - Else, increment.
- Boundary cases
  - Press sampled on the same edge as gap expiry: press wins → PRESS2, no o_short_press.
  - Release sampled on the same edge that long-press is reached: release wins → WAIT_GAP, no o_long_press.
  - Release on the repeat terminal edge: release wins → IDLE, no o_repeat.
  - A third press after a double press starts a new sequence from IDLE.
  - Reset mid-operation: any pending classification is discarded and no pulse is emitted.
  - i_button high when reset deasserts: treated as a new press (→ PRESS1 on the first edge).
  - Illegal state encoding: recover to IDLE.

Decomposition:
- Package button_pkg holds:
  - the state enum (IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD);
  - default timing constants for 50 MHz (LONG/GAP/REPEAT cycles).
- Parameter legality checks use elaboration-time assertions in the module.
- No sub-module: one FSM plus one counter is the natural granularity.
- Top-level integration instantiates debouncer → button_press_classifier.

Test Plan (LONG_CYCLES=20, GAP_CYCLES=8, REPEAT_CYCLES=5):
1. Reset
   - Stimulus: assert i_rst mid-cycle with i_button=1.
   - Response: all outputs 0 immediately; after deassert, o_busy = 1 one edge later.
2. Short press
   - Stimulus: press 5 cycles, release.
   - Response: exactly one o_short_press pulse, following the 8th edge after the release edge; no other pulses; o_busy 0 afterwards.
3. Double press
   - Stimulus: press 5, release 4, press 3, release.
   - Response: one o_double_press on the cycle after the second release edge; no o_short_press.
4. Long plus repeat
   - Stimulus: hold 32 cycles, then release.
   - Response: o_long_press after edge 20; o_repeat after edges 25 and 30; nothing on release.
5. Gap-boundary priority
   - Stimulus: release, then press sampled exactly on the 8th edge after release.
   - Response: PRESS2 entered, no o_short_press; subsequent release → o_double_press.
6. Reset mid-operation
   - Stimulus: press 5, release, pulse i_rst during WAIT_GAP counter=3.
   - Response: no o_short_press ever emitted; state IDLE.

Source files
------------

// File: rtl/button_press_classifier_pkg.sv
// Shared types and default 50 MHz timing for the button press classifier.
//   state_e          : classifier FSM states
//   DEF_*_CYCLES     : default long-press, double-press gap and repeat periods
//   DEF_CNT_W        : counter width that holds the largest default period - 1
package button_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT_GAP  = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } state_e;

  localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;  // 1 s
  localparam int unsigned DEF_GAP_CYCLES    = 12_500_000;  // 250 ms
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;  // 200 ms
  localparam int unsigned DEF_CNT_W         = 26;

endpackage

// File: rtl/button_press_classifier.sv
// Classifies a debounced, synchronous button level into one-cycle gesture
// pulses: short press, double press, long press and auto-repeat while held.
// Ports:
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_button         : debounced button level, 1 = pressed
//   o_short_press    : single short press confirmed (gap expired)
//   o_double_press   : second press of a double press released
//   o_long_press     : hold reached LONG_CYCLES
//   o_repeat         : every REPEAT_CYCLES while held after a long press
//   o_busy           : FSM not in IDLE
module button_press_classifier
  import button_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_short_press,
  output logic o_double_press,
  output logic o_long_press,
  output logic o_repeat,
  output logic o_busy
);

  localparam longint unsigned MAX_CYC =
    (LONG_CYCLES >= GAP_CYCLES)
      ? ((64'(LONG_CYCLES) >= 64'(REPEAT_CYCLES)) ? 64'(LONG_CYCLES) : 64'(REPEAT_CYCLES))
      : ((64'(GAP_CYCLES)  >= 64'(REPEAT_CYCLES)) ? 64'(GAP_CYCLES)  : 64'(REPEAT_CYCLES));

  // Parameter legality, checked at elaboration
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("LONG_CYCLES must be >= 2");
  end
  if (GAP_CYCLES < 2) begin : g_bad_gap
    $error("GAP_CYCLES must be >= 2");
  end
  if ((MAX_CYC - 64'd1) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the largest period");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam bit               REP_EN    = (REPEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] REP_LAST  = REP_EN ? CNT_W'(REPEAT_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_d, double_d, long_d, repeat_d;

  // Next-state, counter and event decode; every state change clears the counter
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_button) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        // Release beats long-press on the same edge
        if (!i_button) begin
          state_d = WAIT_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_GAP: begin
        // A second press beats gap expiry on the same edge
        if (i_button) begin
          state_d = PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESS2: begin
        if (!i_button) begin
          double_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end
      end
      LONG_HELD: begin
        // With repeat disabled the counter stays parked at 0 so it never wraps
        if (!i_button) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (REP_EN && (cnt_q == REP_LAST)) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else if (REP_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      o_short_press  <= 1'b0;
      o_double_press <= 1'b0;
      o_long_press   <= 1'b0;
      o_repeat       <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      o_short_press  <= short_d;
      o_double_press <= double_d;
      o_long_press   <= long_d;
      o_repeat       <= repeat_d;
      o_busy         <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Scoreboard bench for button_press_classifier. Each sequence is a per-edge
// button level list; a run-length reference model derives the expected event
// pulses (edge number + kind) and a monitor pops and compares them.
module tb_button_press_classifier;

  localparam int L = 20;
  localparam int G = 8;
  localparam int R = 5;
  localparam int CW = 5;

  localparam int EV_SHORT  = 1;
  localparam int EV_DOUBLE = 2;
  localparam int EV_LONG   = 3;
  localparam int EV_REPEAT = 4;

  typedef struct {
    int edge_no;
    int kind;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_button = 1'b0;
  logic o_short_press, o_double_press, o_long_press, o_repeat, o_busy;

  exp_t exp_q[$];
  bit   lvl[$];
  int   cur_edge = -1;
  int   total = 0;
  int   bad = 0;

  always #5 i_clk = ~i_clk;

  button_press_classifier #(
    .LONG_CYCLES  (L),
    .GAP_CYCLES   (G),
    .REPEAT_CYCLES(R),
    .CNT_W        (CW)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_button      (i_button),
    .o_short_press (o_short_press),
    .o_double_press(o_double_press),
    .o_long_press  (o_long_press),
    .o_repeat      (o_repeat),
    .o_busy        (o_busy)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d, t=%0t)", name, act, req, cur_edge, $time);
    end
  endtask

  function automatic int run_len(input int i, input bit v);
    int n = 0;
    while ((i + n) < lvl.size() && lvl[i + n] == v) n++;
    return n;
  endfunction

  function automatic void push_ev(input int e, input int kind, input int lim);
    exp_t x;
    x.edge_no = e;
    x.kind    = kind;
    if (e < lim) exp_q.push_back(x);
  endfunction

  // Gesture model over runs of high/low samples, starting idle at edge 0
  function automatic void model(input int lim);
    int n = lvl.size();
    int k = 0;
    while (k < n) begin
      if (!lvl[k]) begin
        k++;
      end else begin
        int p = k;
        int h = run_len(p, 1'b1);
        if (h >= L + 1) begin
          // long needs edge p+L still high; repeats while still high
          push_ev(p + L, EV_LONG, lim);
          for (int t = p + L + R; t <= p + h - 1; t += R) push_ev(t, EV_REPEAT, lim);
          k = p + h;
        end else begin
          int r = p + h;
          int g = run_len(r, 1'b0);
          if (g > G) begin
            push_ev(r + G, EV_SHORT, lim);
            k = r + G + 1;
          end else begin
            int q = r + g;
            int h2 = run_len(q, 1'b1);
            push_ev(q + h2, EV_DOUBLE, lim);
            k = q + h2;
          end
        end
      end
    end
  endfunction

  task automatic add_run(input bit v, input int len);
    for (int i = 0; i < len; i++) lvl.push_back(v);
  endtask

  // Drive one sequence from a fresh reset; rst_at >= 0 re-asserts reset before that edge
  task automatic run_seq(input int rst_at);
    int lim;
    lim = (rst_at < 0) ? lvl.size() : rst_at;
    exp_q.delete();
    model(lim);
    @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    chk("rst_outputs_zero", int'({o_busy, o_short_press, o_double_press, o_long_press, o_repeat}), 0);
    @(negedge i_clk);
    i_rst    = 1'b0;
    i_button = lvl[0];
    cur_edge = 0;
    for (int k = 1; k < lvl.size(); k++) begin
      @(negedge i_clk);
      if (k == 1) chk("busy_after_rst", int'(o_busy), int'(lvl[0]));
      if (k == rst_at) begin
        i_rst = 1'b1;
        #1;
        chk("midrst_outputs_zero", int'({o_busy, o_short_press, o_double_press, o_long_press, o_repeat}), 0);
        break;
      end
      i_button = lvl[k];
      cur_edge = k;
    end
    if (rst_at >= 0) begin
      i_button = 1'b0;
      repeat (2) @(negedge i_clk);
      i_rst    = 1'b0;
      cur_edge = -1;
      repeat (G + 4) @(negedge i_clk);
      chk("post_rst_busy", int'(o_busy), 0);
    end else begin
      @(negedge i_clk);
      chk("end_busy", int'(o_busy), 0);
    end
    chk("leftover_events", exp_q.size(), 0);
    exp_q.delete();
    lvl.delete();
  endtask

  // Monitor: any pulse must be the next expected event at the expected edge
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if ((o_short_press | o_double_press | o_long_press | o_repeat) == 1'b1) begin
        int kind;
        exp_t e;
        chk("one_pulse", $countones({o_short_press, o_double_press, o_long_press, o_repeat}), 1);
        kind = o_short_press  ? EV_SHORT  :
               o_double_press ? EV_DOUBLE :
               o_long_press   ? EV_LONG   : EV_REPEAT;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", kind, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ev_kind", kind, e.kind);
          chk("ev_edge", cur_edge, e.edge_no);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clk);

    // Reset clears a live long pulse mid-cycle; button high at deassert
    add_run(1, 25);
    run_seq(21);
    // Short press
    add_run(0, 2); add_run(1, 5); add_run(0, G + 4);
    run_seq(-1);
    // Double press
    add_run(0, 1); add_run(1, 5); add_run(0, 4); add_run(1, 3); add_run(0, G + 4);
    run_seq(-1);
    // Long plus repeat
    add_run(1, 32); add_run(0, G + 4);
    run_seq(-1);
    // Second press on the gap-expiry edge
    add_run(0, 1); add_run(1, 5); add_run(0, G); add_run(1, 3); add_run(0, G + 4);
    run_seq(-1);
    // Reset during WAIT_GAP with counter at 3
    add_run(0, 1); add_run(1, 5); add_run(0, 20);
    run_seq(10);
    // Release on the long-press edge
    add_run(0, 1); add_run(1, L); add_run(0, G + 4);
    run_seq(-1);
    // Release on the repeat terminal edge
    add_run(0, 1); add_run(1, L + R); add_run(0, G + 4);
    run_seq(-1);
    // Third press after a double press
    add_run(0, 1); add_run(1, 2); add_run(0, 2); add_run(1, 2); add_run(0, 1);
    add_run(1, 2); add_run(0, G + 4);
    run_seq(-1);

    // Randomized gestures biased toward the timing boundaries
    for (int s = 0; s < 40; s++) begin
      int nruns;
      add_run(0, $urandom_range(0, 2));
      nruns = $urandom_range(1, 5);
      for (int j = 0; j < nruns; j++) begin
        case ($urandom_range(0, 3))
          0:       add_run(1, $urandom_range(1, 6));
          1:       add_run(1, $urandom_range(L - 1, L + 1));
          2:       add_run(1, $urandom_range(L + R - 1, L + 2 * R + 1));
          default: add_run(1, $urandom_range(1, L + 12));
        endcase
        case ($urandom_range(0, 2))
          0:       add_run(0, $urandom_range(1, G - 1));
          1:       add_run(0, $urandom_range(G - 1, G + 1));
          default: add_run(0, $urandom_range(G + 1, G + 6));
        endcase
      end
      add_run(0, G + 4);
      run_seq(-1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
